// File: rtl/ch2_div_ctrl.sv
// ch2_div_ctrl: run/stop sequencer, tap select and boundary tick for a 4-stage clock-enable divider.
// Define CH2_DIV_CTRL_ONESHOT_EN to make each run stop at its first tap boundary.
module ch2_div_ctrl #(
    parameter int SELW = 2,
    localparam int WIDTH = 2 ** SELW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [SELW-1:0] sel,
    input  logic            load,
    output logic            load_ack,
    output logic [WIDTH-1:0] q,
    output logic            tick,
    output logic            busy,
    output logic [SELW-1:0] asel
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] q_n, tap_mask;
    logic b, apply;
    // Low asel+1 bits of q form the active tap; all ones there marks its boundary.
    assign tap_mask = ~({WIDTH{1'b1}} << asel << 1);
    assign b = (state != IDLE) && ((q & tap_mask) == tap_mask);
    // A request held through its own ack cycle is not seen twice.
    assign apply = load && !load_ack && (state == IDLE || b);
    always_comb begin
        state_n = state;
        q_n = q + 1'b1;
        if (state == IDLE) begin
            q_n = '0;
            if (start && !stop) state_n = RUN;
        end else if (state == RUN) begin
            if (stop) state_n = STOPPING;
`ifdef CH2_DIV_CTRL_ONESHOT_EN
            if (b) begin
                q_n = '0;
                state_n = IDLE;
            end
`endif
        end else if (b) begin
            q_n = '0;
            state_n = IDLE;
        end else if (start && !stop) begin
            state_n = RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            q <= '0;
            asel <= '0;
            tick <= 1'b0;
            load_ack <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            q <= q_n;
            tick <= b;
            load_ack <= apply;
            busy <= state_n != IDLE;
            if (apply) asel <= sel;
        end
    end
endmodule
